// File: rtl/axi4_rd_rr_interconnect_m2s_pkg.sv
// Shared helpers and types for the AXI4 read interconnect.
// Provides the port-index width function and the AXI length type.
package axi4_icon_pkg;

    localparam int AXI_LEN_W = 8;
    typedef logic [AXI_LEN_W-1:0] axi_len_t;

    // Port-index width; a single port index bit is kept even for tiny NUM
    function automatic int icon_nsize(input int num);
        return (num <= 2) ? 1 : $clog2(num);
    endfunction

endpackage

// File: rtl/axi4_rd_rr_interconnect_m2s_arb.sv
// Round-robin one-hot arbiter: the first requester at or after the pointer wins,
// and the pointer moves past the winner only when a grant is actually issued.
import axi4_icon_pkg::*;

module rr_arbiter_onehot #(
    parameter int NUM = 4
) (
    input  logic           clock,
    input  logic           rst,
    input  logic [NUM-1:0] req,
    input  logic           en,
    output logic [NUM-1:0] grant
);

    localparam int NSIZE = icon_nsize(NUM);

    logic [NSIZE-1:0] ptr_reg;
    logic [NSIZE-1:0] ptr_next;

    always_comb begin : pick
        int  idx;
        logic found;
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = (idx == NUM - 1) ? '0 : NSIZE'(idx + 1);
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/axi4_rd_rr_interconnect_m2s.sv
// N-to-1 AXI4 read interconnect: round-robin AR arbitration with per-port outstanding
// limits and combinational R routing by the low RID bits. Optional: AXI4_RD_ICON_TRACK_EN.
import axi4_icon_pkg::*;

module axi4_rd_rr_interconnect_m2s #(
    parameter  int NUM      = 4,
    parameter  int ASIZE    = 32,
    parameter  int DSIZE    = 128,
    parameter  int SIDSIZE  = 4,
    parameter  int MAX_OUTS = 8,
    localparam int NSIZE    = icon_nsize(NUM),
    localparam int MIDSIZE  = SIDSIZE + NSIZE
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NUM-1:0]         s_arvalid,
    output logic [NUM-1:0]         s_arready,
    input  logic [NUM*SIDSIZE-1:0] s_arid,
    input  logic [NUM*ASIZE-1:0]   s_araddr,
    input  logic [NUM*8-1:0]       s_arlen,
    output logic [NUM-1:0]         s_rvalid,
    input  logic [NUM-1:0]         s_rready,
    output logic [SIDSIZE-1:0]     s_rid,
    output logic [DSIZE-1:0]       s_rdata,
    output logic                   s_rlast,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [MIDSIZE-1:0]     m_arid,
    output logic [ASIZE-1:0]       m_araddr,
    output logic [7:0]             m_arlen,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [MIDSIZE-1:0]     m_rid,
    input  logic [DSIZE-1:0]       m_rdata,
    input  logic                   m_rlast,
`ifdef AXI4_RD_ICON_TRACK_EN
    output logic [MIDSIZE-1:0]     track_arid,
    output logic [MIDSIZE-1:0]     track_rid,
`endif
    output logic                   err_unmapped
);

    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam logic [NSIZE:0] NUM_W = (NSIZE + 1)'(NUM);

    logic                 m_arvalid_reg;
    logic [MIDSIZE-1:0]   m_arid_reg;
    logic [ASIZE-1:0]     m_araddr_reg;
    axi_len_t             m_arlen_reg;
    logic                 err_unmapped_reg;
    logic [CW-1:0]        outs_reg [NUM];

    logic                 loadable;
    logic [NUM-1:0]       eligible;
    logic [NUM-1:0]       grant;
    logic [NUM-1:0]       route_hot;
    logic [NSIZE-1:0]     gnt_idx;
    logic [NSIZE-1:0]     rport;
    logic                 mapped;
    logic                 r_hs;

    assign loadable = !m_arvalid_reg || m_arready;

    rr_arbiter_onehot #(.NUM(NUM)) u_arb (
        .clock (clock),
        .rst   (rst),
        .req   (eligible),
        .en    (loadable),
        .grant (grant)
    );

    // Held low while reset is asserted so no handshake can slip through
    assign s_arready = grant & {NUM{!rst}};

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM; k++) begin
            if (grant[k]) begin
                gnt_idx = NSIZE'(k);
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            m_arvalid_reg <= 1'b0;
            m_arid_reg    <= '0;
            m_araddr_reg  <= '0;
            m_arlen_reg   <= '0;
        end else if (loadable) begin
            m_arvalid_reg <= |grant;
            if (|grant) begin
                m_arid_reg   <= {s_arid[gnt_idx*SIDSIZE +: SIDSIZE], gnt_idx};
                m_araddr_reg <= s_araddr[gnt_idx*ASIZE +: ASIZE];
                m_arlen_reg  <= s_arlen[gnt_idx*AXI_LEN_W +: AXI_LEN_W];
            end
        end
    end

    assign m_arvalid = m_arvalid_reg;
    assign m_arid    = m_arid_reg;
    assign m_araddr  = m_araddr_reg;
    assign m_arlen   = m_arlen_reg;

    // R routing: the low RID bits select the upstream port
    assign rport  = m_rid[NSIZE-1:0];
    assign mapped = ({1'b0, rport} < NUM_W);

    assign m_rready = mapped ? |(s_rready & route_hot) : 1'b1;
    assign r_hs     = m_rvalid && m_rready;
    assign s_rid    = m_rid[MIDSIZE-1:NSIZE];
    assign s_rdata  = m_rdata;
    assign s_rlast  = m_rlast;

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_port
            localparam logic [NSIZE-1:0] KI = NSIZE'(gi);
            logic inc;
            logic dec;

            assign route_hot[gi] = mapped && (rport == KI);
            assign s_rvalid[gi]  = m_rvalid && route_hot[gi];
            assign eligible[gi]  = s_arvalid[gi] && (outs_reg[gi] < CW'(MAX_OUTS));

            assign inc = s_arvalid[gi] && s_arready[gi];
            // A last beat with nothing outstanding is ignored rather than underflowing
            assign dec = r_hs && m_rlast && route_hot[gi] && (outs_reg[gi] != '0);

            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    outs_reg[gi] <= '0;
                end else if (inc && !dec) begin
                    outs_reg[gi] <= outs_reg[gi] + 1'b1;
                end else if (dec && !inc) begin
                    outs_reg[gi] <= outs_reg[gi] - 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_unmapped_reg <= 1'b0;
        end else if (m_rvalid && !mapped) begin
            err_unmapped_reg <= 1'b1;
        end
    end

    assign err_unmapped = err_unmapped_reg;

`ifdef AXI4_RD_ICON_TRACK_EN
    logic [MIDSIZE-1:0] track_arid_reg;
    logic [MIDSIZE-1:0] track_rid_reg;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            track_arid_reg <= '0;
            track_rid_reg  <= '0;
        end else begin
            if (m_arvalid_reg && m_arready) begin
                track_arid_reg <= m_arid_reg;
            end
            if (r_hs) begin
                track_rid_reg <= m_rid;
            end
        end
    end

    assign track_arid = track_arid_reg;
    assign track_rid  = track_rid_reg;
`endif

endmodule
